// File: rtl/clock_pkg.sv
// Shared constants for the digital clock timekeeping core.
// State codes double as the set_sel value driven to the display stage.
package clock_pkg;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SET_H = 2'd1;
  localparam logic [1:0] SET_M = 2'd2;
  localparam logic [1:0] SET_S = 2'd3;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Mode key cycles RUN -> SET_H -> SET_M -> SET_S -> RUN.
  function automatic logic [1:0] next_state(input logic [1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, modulo MOD, with synchronous inc/dec/clr.
// The carry output is combinational so a chained counter updates on the same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max, at_zero;

  always_comb begin
    at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    tens_d  = tens_q;
    ones_d  = ones_q;
    carry   = 1'b0;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc && !dec) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
        carry  = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec && !inc) begin
      // Wrapping down from zero lands on MOD-1, never on an illegal code.
      if (at_zero) begin
        tens_d = MAX_T;
        ones_d = MAX_O;
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping and time-set core: BCD hh:mm:ss driven by a 1 Hz prescaler,
// with a mode FSM for editing each field and a blink enable for the display.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CNT_1S     = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [3:0] hour_t,
  output logic [3:0] hour_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] set_sel,
  output logic       blink,
  output logic       sec_tick
);

  localparam int PW = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_1S - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;
  logic          run, edit_inc, edit_dec;

  logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic sec_carry, min_carry, hour_carry_unused;

  // A mode press always wins: it drops inc/dec and restarts prescaler and blink.
  always_comb begin
    run      = (state_q == RUN);
    state_d  = key_mode ? next_state(state_q) : state_q;
    edit_inc = !run && !key_mode && key_inc;
    edit_dec = !run && !key_mode && key_dec;

    tick_d  = run && !key_mode && (presc_q == PRESC_LAST);
    presc_d = '0;
    if (run && !key_mode && !tick_d) begin
      presc_d = presc_q + 1'b1;
    end

    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (!run && !key_mode) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  // Carries ripple only while running; in set modes each field wraps on its own.
  assign sec_inc  = tick_d | (edit_inc && (state_q == SET_S));
  assign sec_dec  = edit_dec && (state_q == SET_S);
  assign min_inc  = (run && sec_carry) | (edit_inc && (state_q == SET_M));
  assign min_dec  = edit_dec && (state_q == SET_M);
  assign hour_inc = (run && min_carry) | (edit_inc && (state_q == SET_H));
  assign hour_dec = edit_dec && (state_q == SET_H);

  bcd_mod_counter #(.MOD(SEC_MAX + 1)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .dec   (sec_dec),
    .clr   (1'b0),
    .tens  (sec_t),
    .ones  (sec_o),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MAX + 1)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .dec   (min_dec),
    .clr   (1'b0),
    .tens  (min_t),
    .ones  (min_o),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MAX + 1)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .dec   (hour_dec),
    .clr   (1'b0),
    .tens  (hour_t),
    .ones  (hour_o),
    .carry (hour_carry_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
    end
  end

  assign set_sel  = state_q;
  assign blink    = blink_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed self-checking bench for clock_time_core with a 10-cycle second
// and a 4-cycle blink half-period.
module tb_clock_time_core;

  logic        clk;
  logic        rst_n;
  logic        key_mode, key_inc, key_dec;
  logic [3:0]  hour_t, hour_o, min_t, min_o, sec_t, sec_o;
  logic [1:0]  set_sel;
  logic        blink, sec_tick;
  logic [23:0] time_now;

  int checks = 0;
  int errors = 0;

  clock_time_core #(.CNT_1S(10), .BLINK_HALF(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .key_dec  (key_dec),
    .hour_t   (hour_t),
    .hour_o   (hour_o),
    .min_t    (min_t),
    .min_o    (min_o),
    .sec_t    (sec_t),
    .sec_o    (sec_o),
    .set_sel  (set_sel),
    .blink    (blink),
    .sec_tick (sec_tick)
  );

  assign time_now = {hour_t, hour_o, min_t, min_o, sec_t, sec_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle key flags, applied between falling edges; returns just after the effect.
  task automatic press(input logic m, input logic i, input logic d);
    @(negedge clk);
    key_mode = m;
    key_inc  = i;
    key_dec  = d;
    @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    #12;
    checks++;
    if (time_now !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL reset_time: got %h expected 000000", time_now);
    end
    checks++;
    if ({set_sel, blink, sec_tick} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got sel=%0d blink=%b tick=%b expected sel=0 blink=1 tick=0",
               set_sel, blink, sec_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run_minute();
    int last = 0;
    int ticks = 0;
    int bad_spacing = 0;
    int bad_ctrl = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) begin
        ticks++;
        if (k - last != 10) bad_spacing++;
        last = k;
      end
      if (set_sel !== 2'd0 || blink !== 1'b1) bad_ctrl++;
      if (k == 305) begin
        checks++;
        if (time_now !== 24'h000030) begin
          errors++;
          $display("[TB] FAIL run_mid_time: got %h expected 000030", time_now);
        end
      end
    end
    checks++;
    if (ticks != 60) begin
      errors++;
      $display("[TB] FAIL run_tick_count: got %0d expected 60", ticks);
    end
    checks++;
    if (bad_spacing != 0) begin
      errors++;
      $display("[TB] FAIL run_tick_spacing: got %0d bad gaps expected 0", bad_spacing);
    end
    checks++;
    if (bad_ctrl != 0) begin
      errors++;
      $display("[TB] FAIL run_sel_blink: got %0d bad cycles expected 0", bad_ctrl);
    end
    checks++;
    if (time_now !== 24'h000100) begin
      errors++;
      $display("[TB] FAIL run_minute_time: got %h expected 000100", time_now);
    end
  endtask

  task automatic test_preset_rollover();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_now !== 24'h230100) begin
      errors++;
      $display("[TB] FAIL preset_hour_dec: got %h expected 230100", time_now);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_now !== 24'h235958) begin
      errors++;
      $display("[TB] FAIL preset_value: got %h expected 235958", time_now);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (set_sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL preset_back_to_run: got %0d expected 0", set_sel);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++;
        if ({time_now, sec_tick} !== {24'h235958, 1'b0}) begin
          errors++;
          $display("[TB] FAIL first_tick_early: got %h tick=%b expected 235958 tick=0", time_now, sec_tick);
        end
      end
      if (k == 10) begin
        checks++;
        if ({time_now, sec_tick} !== {24'h235959, 1'b1}) begin
          errors++;
          $display("[TB] FAIL tick_to_59: got %h tick=%b expected 235959 tick=1", time_now, sec_tick);
        end
      end
      if (k == 20) begin
        checks++;
        if ({time_now, sec_tick} !== {24'h000000, 1'b1}) begin
          errors++;
          $display("[TB] FAIL day_rollover: got %h tick=%b expected 000000 tick=1", time_now, sec_tick);
        end
      end
    end
  endtask

  task automatic test_set_hour();
    int ticks = 0;
    int changes = 0;
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (set_sel !== 2'd1) begin
      errors++;
      $display("[TB] FAIL enter_set_h: got %0d expected 1", set_sel);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_now !== 24'h230000) begin
      errors++;
      $display("[TB] FAIL hour_dec_wrap: got %h expected 230000", time_now);
    end
    repeat (4) press(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_now !== 24'h190000) begin
      errors++;
      $display("[TB] FAIL hour_dec_borrow: got %h expected 190000", time_now);
    end
    repeat (5) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (time_now !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL hour_inc_wrap: got %h expected 000000", time_now);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) ticks++;
      if (time_now !== 24'h000000) changes++;
    end
    checks++;
    if (ticks != 0 || changes != 0) begin
      errors++;
      $display("[TB] FAIL set_frozen: got ticks=%0d changes=%0d expected 0 0", ticks, changes);
    end
  endtask

  task automatic test_set_minute_second();
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 61; k++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if ({set_sel, time_now} !== {2'd2, 24'h000100}) begin
      errors++;
      $display("[TB] FAIL minute_61_inc: got sel=%0d %h expected sel=2 000100", set_sel, time_now);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    checks++;
    if ({set_sel, time_now} !== {2'd3, 24'h000100}) begin
      errors++;
      $display("[TB] FAIL inc_dec_together: got sel=%0d %h expected sel=3 000100", set_sel, time_now);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_now !== 24'h000159) begin
      errors++;
      $display("[TB] FAIL sec_dec_no_borrow: got %h expected 000159", time_now);
    end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (time_now !== 24'h000100) begin
      errors++;
      $display("[TB] FAIL sec_inc_no_carry: got %h expected 000100", time_now);
    end
  endtask

  task automatic test_mode_priority_blink();
    logic exp_blink;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (set_sel !== 2'd1) begin
      errors++;
      $display("[TB] FAIL wrap_to_set_h: got %0d expected 1", set_sel);
    end
    press(1'b1, 1'b1, 1'b0);
    checks++;
    if ({set_sel, time_now, blink} !== {2'd2, 24'h000100, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mode_beats_inc: got sel=%0d %h blink=%b expected sel=2 000100 blink=1",
               set_sel, time_now, blink);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_blink = ((k / 4) % 2 == 0);
      checks++;
      if (blink !== exp_blink) begin
        errors++;
        $display("[TB] FAIL blink_phase_%0d: got %b expected %b", k, blink, exp_blink);
      end
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({set_sel, blink} !== {2'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL blink_restart: got sel=%0d blink=%b expected sel=3 blink=1", set_sel, blink);
    end
  endtask

  task automatic test_reset_midcount();
    int first = 0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    repeat (37) press(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({set_sel, time_now} !== {2'd3, 24'h000037}) begin
      errors++;
      $display("[TB] FAIL preset_37: got sel=%0d %h expected sel=3 000037", set_sel, time_now);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({time_now, set_sel, blink, sec_tick} !== {24'h000000, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h sel=%0d blink=%b tick=%b expected 000000 sel=0 blink=1 tick=0",
               time_now, set_sel, blink, sec_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30 && first == 0; k++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) first = k;
    end
    checks++;
    if (first != 10) begin
      errors++;
      $display("[TB] FAIL tick_after_reset: got cycle %0d expected 10 (0 = none within 30)", first);
    end
  endtask

  initial begin
    $display("[TB] clock_time_core directed test start");
    test_reset();
    test_run_minute();
    test_preset_rollover();
    test_set_hour();
    test_set_minute_second();
    test_mode_priority_blink();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
Timekeeping and time-set core for the digital clock. Sits directly downstream of the per-key debouncers and consumes their one-cycle press flags (mode, increment, decrement). Maintains BCD hh:mm:ss from a clock-derived 1 Hz tick. Drives the display stage with BCD digits, the field being edited and a blink enable.

Parameters:
CNT_1S, 50_000_000, clk cycles per second; prescaler counts 0..CNT_1S-1
BLINK_HALF, 12_500_000, clk cycles per blink half-period in set modes

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
key_mode  in  1  debounced press flag; advances mode
key_inc  in  1  debounced press flag; +1 on selected field
key_dec  in  1  debounced press flag; -1 on selected field
hour_t  out  4  BCD hour tens, 0..2
hour_o  out  4  BCD hour ones
min_t  out  4  BCD minute tens, 0..5
min_o  out  4  BCD minute ones
sec_t  out  4  BCD second tens, 0..5
sec_o  out  4  BCD second ones
set_sel  out  2  0=RUN, 1=hour, 2=minute, 3=second being edited
blink  out  1  display enable for selected field; 1 in RUN
sec_tick  out  1  one-cycle pulse at each counted second (RUN only)

Behaviour:
- Reset (async, rst_n=0):
  - time 00:00:00, state RUN, prescaler 0, blink counter 0.
  - set_sel=0, blink=1, sec_tick=0.
- All outputs are registered. Every effect is visible on the cycle after its cause.
- Input flags are level-sampled each cycle. No edge detection here: a flag high for N cycles acts N times.
- FSM states and transitions, taken on key_mode=1:
  - RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - set_sel equals the state encoding 0..3.
- RUN:
  - Prescaler increments every cycle.
  - At CNT_1S-1 the prescaler wraps to 0 and sec_tick=1 for one cycle. Seconds +1 on that same edge.
  - Seconds 59->00 carries minute +1. Minutes 59->00 carries hour +1. Hours 23->00 with no further carry.
  - key_inc and key_dec are ignored.
- SET_H / SET_M / SET_S:
  - Time is frozen, prescaler is held at 0, sec_tick=0.
  - key_inc adds 1 to the selected field modulo its range (hour 24, minute/second 60).
  - key_dec subtracts 1 modulo its range: 00->23 for hours, 00->59 for minutes/seconds.
  - No carry or borrow into neighbouring fields.
- Simultaneous events:
  - key_mode together with key_inc/key_dec: mode wins and inc/dec are dropped that cycle.
  - key_inc together with key_dec: no change.
- Leaving SET_S -> RUN: the prescaler restarts from 0, so the first sec_tick occurs CNT_1S cycles after the transition cycle.
- Blink:
  - Counter 0..BLINK_HALF-1 runs only in set states. On wrap it toggles blink.
  - Any state change clears the counter and sets blink=1.
  - In RUN, blink is forced to 1.
- BCD rules:
  - Ones digit 9->0 increments tens; ones 0->9 on decrement borrows from tens.
  - Hour tens=2 limits ones to 0..3. Illegal BCD codes never appear.
- Reset mid-operation: immediate return to reset values, whatever the state or prescaler phase.

Decomposition:
- Package clock_pkg holds:
  - state encodings RUN/SET_H/SET_M/SET_S (2-bit, equal to set_sel);
  - BCD limits: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- Sub-module bcd_mod_counter:
  - two BCD digits with inc, dec and clr inputs plus a carry-out pulse;
  - parameter MOD (60 or 24);
  - instantiated three times, with the carry chain enabled only in RUN.

Test Plan (CNT_1S=10, BLINK_HALF=4):
1. Release reset, run 600 cycles -> 60 sec_tick pulses spaced 10 cycles apart; time 00:01:00, set_sel=0, blink=1 throughout.
2. Preset 23:59:58 via set modes, return to RUN, run 20 cycles -> 23:59:59 then 00:00:00; hour_t=0, hour_o=0.
3. From RUN pulse key_mode once -> set_sel=1 next cycle. Pulse key_dec at 00 -> hour 23; key_inc -> 00. Prescaler stays 0 and no sec_tick for 100 cycles.
4. In SET_M, 61 single-cycle key_inc pulses from 00 -> minute 01, hour unchanged (no carry). In SET_S, key_inc and key_dec in the same cycle -> no change.
5. In SET_H, key_mode and key_inc in the same cycle -> set_sel=2, hour unchanged. blink toggles every 4 cycles, and is 1 on the cycle after any mode change.
6. Assert rst_n=0 mid-count at 00:00:37 in SET_S -> within the same cycle all digits 0, set_sel=0, blink=1, sec_tick=0. After release, the first tick comes 10 cycles later.
